// File: rtl/rat_io_hub.sv
// I/O port hub for the RAT MCU: synchronised input ports, registered output ports,
// and a debounced button interrupt with pending/enable/acknowledge control.
module rat_io_hub #(
   parameter int unsigned N_IN      = 4,
   parameter int unsigned N_OUT     = 4,
   parameter logic [7:0]  IN_BASE   = 8'h20,
   parameter logic [7:0]  OUT_BASE  = 8'h40,
   parameter logic [7:0]  CTRL_ID   = 8'h60,
   parameter int unsigned DB_CYCLES = 50000
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [7:0]         PORT_ID,
   input  logic [7:0]         OUT_PORT,
   input  logic               IO_STRB,
   output logic [7:0]         IN_PORT,
   input  logic [8*N_IN-1:0]  IN_DATA,
   output logic [8*N_OUT-1:0] OUT_DATA,
   input  logic               BTN_INT,
   output logic               INTR
);

   localparam int unsigned IN_LO   = 32'(IN_BASE);
   localparam int unsigned IN_HI   = IN_LO + N_IN - 1;
   localparam int unsigned OUT_LO  = 32'(OUT_BASE);
   localparam int unsigned OUT_HI  = OUT_LO + N_OUT - 1;
   localparam int unsigned CTRL_LO = 32'(CTRL_ID);
   localparam int          CW      = $clog2(DB_CYCLES);

   generate
      if (N_IN < 1 || N_IN > 16 || N_OUT < 1 || N_OUT > 16) begin : g_bad_count
         $error("rat_io_hub: N_IN and N_OUT must be in 1..16");
      end
      if (IN_HI > 255 || OUT_HI > 255) begin : g_bad_range
         $error("rat_io_hub: port range exceeds 8'hFF");
      end
      if ((IN_LO <= OUT_HI && OUT_LO <= IN_HI) ||
          (CTRL_LO >= IN_LO && CTRL_LO <= IN_HI) ||
          (CTRL_LO >= OUT_LO && CTRL_LO <= OUT_HI)) begin : g_overlap
         $error("rat_io_hub: input range, output range and CTRL_ID overlap");
      end
      if (DB_CYCLES < 2) begin : g_bad_db
         $error("rat_io_hub: DB_CYCLES must be at least 2");
      end
   endgenerate

   logic [8*N_IN-1:0]  in_s1_q, in_s1_d, in_s2_q, in_s2_d;
   logic [8*N_OUT-1:0] out_q, out_d;
   logic               btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               deb_q, deb_d, deb_prev_q, deb_prev_d;
   logic               pending_q, pending_d, int_en_q, int_en_d;
   logic               ctrl_wr, deb_rise;

   always_comb begin
      in_s1_d    = IN_DATA;
      in_s2_d    = in_s1_q;
      btn_s1_d   = BTN_INT;
      btn_s2_d   = btn_s1_q;
      deb_prev_d = deb_q;

      out_d = out_q;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if (IO_STRB && PORT_ID == 8'(OUT_LO + k)) begin
            out_d[8*k +: 8] = OUT_PORT;
         end
      end

      // Counter runs only while the synced button disagrees with the debounced level.
      deb_d = deb_q;
      cnt_d = '0;
      if (btn_s2_q != deb_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            deb_d = btn_s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      ctrl_wr  = IO_STRB && (PORT_ID == CTRL_ID);
      int_en_d = ctrl_wr ? OUT_PORT[0] : int_en_q;
      deb_rise = deb_q & ~deb_prev_q;
      // A new rising event beats a simultaneous acknowledge.
      pending_d = deb_rise | (pending_q & ~(ctrl_wr & OUT_PORT[1]));
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         in_s1_q    <= '0;
         in_s2_q    <= '0;
         out_q      <= '0;
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         cnt_q      <= '0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         pending_q  <= 1'b0;
         int_en_q   <= 1'b0;
      end else begin
         in_s1_q    <= in_s1_d;
         in_s2_q    <= in_s2_d;
         out_q      <= out_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         pending_q  <= pending_d;
         int_en_q   <= int_en_d;
      end
   end

   always_comb begin
      IN_PORT = 8'h00;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (PORT_ID == 8'(IN_LO + k)) begin
            IN_PORT = in_s2_q[8*k +: 8];
         end
      end
      if (PORT_ID == CTRL_ID) begin
         IN_PORT = {6'b0, pending_q, int_en_q};
      end
   end

   assign OUT_DATA = out_q;
   assign INTR     = pending_q & int_en_q;

endmodule

// File: tb/tb_rat_io_hub.sv
// Bench for rat_io_hub: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of ports, debounce window and interrupt flags.
module tb_rat_io_hub;
   localparam int          N_IN  = 4;
   localparam int          N_OUT = 4;
   localparam logic [7:0]  IN_B  = 8'h20;
   localparam logic [7:0]  OUT_B = 8'h40;
   localparam logic [7:0]  CTRL  = 8'h60;
   localparam int          DB    = 8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  port_id, out_port, in_port;
   logic        io_strb, btn, intr;
   logic [31:0] in_data, out_data;

   int n_cmp = 0;
   int n_mis = 0;
   int n_txn = 0;

   // reference model state
   logic [7:0]  m_out [N_OUT];
   logic [31:0] in_hist [$];
   logic        btn_hist [$];
   logic        m_int_en, m_pending, m_deb, m_rose;
   int          m_run;

   rat_io_hub #(
      .N_IN(N_IN), .N_OUT(N_OUT), .IN_BASE(IN_B), .OUT_BASE(OUT_B),
      .CTRL_ID(CTRL), .DB_CYCLES(DB)
   ) dut (
      .CLK(clk), .RESET_N(rst_n), .PORT_ID(port_id), .OUT_PORT(out_port),
      .IO_STRB(io_strb), .IN_PORT(in_port), .IN_DATA(in_data),
      .OUT_DATA(out_data), .BTN_INT(btn), .INTR(intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_OUT; k++) m_out[k] = 8'h00;
      in_hist.delete();
      btn_hist.delete();
      in_hist.push_back(32'h0); in_hist.push_back(32'h0);
      btn_hist.push_back(1'b0); btn_hist.push_back(1'b0);
      m_int_en = 1'b0; m_pending = 1'b0; m_deb = 1'b0; m_rose = 1'b0; m_run = 0;
   endtask

   function automatic logic [31:0] model_out();
      logic [31:0] v;
      for (int k = 0; k < N_OUT; k++) v[8*k +: 8] = m_out[k];
      return v;
   endfunction

   // Synced inputs seen by the MCU are the sample taken two edges back.
   function automatic logic [7:0] model_read(input logic [7:0] id);
      logic [31:0] v;
      int off;
      v = in_hist[0];
      off = int'(id) - int'(IN_B);
      if (off >= 0 && off < N_IN) return v[8*off +: 8];
      if (id == CTRL) return {6'b0, m_pending, m_int_en};
      return 8'h00;
   endfunction

   // One clock edge: advance the model on the pre-edge inputs, then compare.
   task automatic step();
      logic btn_s, rose, ack;
      int off;
      btn_s = btn_hist[0];
      rose  = m_rose;
      ack   = 1'b0;
      if (io_strb) begin
         off = int'(port_id) - int'(OUT_B);
         if (off >= 0 && off < N_OUT) m_out[off] = out_port;
         if (port_id == CTRL) begin
            m_int_en = out_port[0];
            ack = out_port[1];
         end
      end
      if (rose) m_pending = 1'b1;
      else if (ack) m_pending = 1'b0;
      m_rose = 1'b0;
      if (btn_s != m_deb) begin
         m_run++;
         if (m_run == DB) begin
            m_deb = btn_s;
            m_run = 0;
            m_rose = btn_s;
         end
      end else begin
         m_run = 0;
      end
      in_hist.push_back(in_data);  void'(in_hist.pop_front());
      btn_hist.push_back(btn);     void'(btn_hist.pop_front());
      @(posedge clk);
      #1;
      n_txn++;
      $display("txn %0d id=%02h strb=%0b wd=%02h btn=%0b rd=%02h out=%08h intr=%0b",
               n_txn, port_id, io_strb, out_port, btn, in_port, out_data, intr);
      check_val("out_data", out_data, model_out());
      check_val("intr", intr, m_pending & m_int_en);
      check_val("in_port", in_port, model_read(port_id));
   endtask

   task automatic async_reset_check();
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_out", out_data, 32'h0);
      check_val("rst_intr", intr, 1'b0);
      port_id = CTRL;
      #0.1;
      check_val("rst_ctrl", in_port, 8'h00);
      model_reset();
      #0.9 rst_n = 1'b1;
   endtask

   // Raise the button and confirm pending appears exactly 2+DB+1 edges later.
   task automatic rise_and_count(input string tag);
      port_id = CTRL; io_strb = 1'b0; btn = 1'b1;
      for (int i = 1; i <= DB + 3; i++) begin
         step();
         check_val(tag, in_port[1], (i >= DB + 3) ? 1'b1 : 1'b0);
      end
   endtask

   initial begin
      int hold;
      int sel;
      rst_n = 1'b0; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
      in_data = 32'h0; btn = 1'b0;
      model_reset();

      // 1: reset state, no clock edge yet
      #3;
      check_val("init_out", out_data, 32'h0);
      check_val("init_intr", intr, 1'b0);
      port_id = CTRL;
      #1;
      check_val("init_ctrl", in_port, 8'h00);
      #3 rst_n = 1'b1;

      // 2: output write, then a non-strobed attempt
      port_id = 8'h42; out_port = 8'hA5; io_strb = 1'b1;
      step();
      check_val("wr42", out_data, 32'h00A5_0000);
      out_port = 8'h5A; io_strb = 1'b0;
      step();
      check_val("nostrb", out_data, 32'h00A5_0000);

      // 3: input read latency and an unmapped address
      in_data = 32'h0000_3C00; port_id = 8'h21;
      step();
      check_val("in_lat1", in_port, 8'h00);
      step();
      check_val("in_lat2", in_port, 8'h3C);
      port_id = 8'h90;
      step();
      check_val("unmapped", in_port, 8'h00);

      // 4: short bounces never register, a long hold does
      port_id = CTRL;
      for (int p = 0; p < 3; p++) begin
         btn = 1'b1; repeat (5) step();
         btn = 1'b0; repeat (5) step();
      end
      check_val("bounce_pend", in_port[1], 1'b0);
      rise_and_count("db_edge");
      port_id = CTRL; out_port = 8'h01; io_strb = 1'b1;
      step();
      check_val("intr_on", intr, 1'b1);

      // 5: acknowledge colliding with a fresh event, then a lone acknowledge
      io_strb = 1'b0; btn = 1'b0;
      repeat (DB + 4) step();
      check_val("fall_keep", in_port[1], 1'b1);
      btn = 1'b1;
      repeat (DB + 2) step();
      io_strb = 1'b1; out_port = 8'h03;
      step();
      check_val("coll_pend", in_port[1], 1'b1);
      check_val("coll_intr", intr, 1'b1);
      step();
      check_val("ack_pend", in_port[1], 1'b0);
      check_val("ack_intr", intr, 1'b0);

      // 6: reset in the middle of a debounce window
      io_strb = 1'b1; port_id = 8'h43; out_port = 8'h77;
      step();
      io_strb = 1'b0; btn = 1'b0; port_id = CTRL;
      repeat (DB + 4) step();
      btn = 1'b1;
      repeat (6) step();
      async_reset_check();
      rise_and_count("db_after_rst");

      // randomized traffic
      hold = 1;
      for (int n = 0; n < 500; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1: port_id = IN_B + 8'($urandom_range(0, N_IN - 1));
            2, 3: port_id = OUT_B + 8'($urandom_range(0, N_OUT - 1));
            4:    port_id = CTRL;
            default: port_id = 8'($urandom);
         endcase
         io_strb  = ($urandom_range(0, 2) == 0);
         out_port = 8'($urandom);
         if ($urandom_range(0, 3) == 0) in_data = $urandom;
         hold--;
         if (hold == 0) begin
            btn = ~btn;
            hold = $urandom_range(1, 14);
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
